// File: rtl/framebuffer_sched_pkg.sv
// Shared constants for the framebuffer command scheduler:
// buffer indices, default buffer count and FSM state encoding.
package framebuffer_sched_pkg;

    localparam int FB_NUM_BUFFERS = 3;

    localparam int FB_COLOR   = 0;
    localparam int FB_DEPTH   = 1;
    localparam int FB_STENCIL = 2;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_COMMIT_ISSUE = 3'd1;
    localparam logic [2:0] ST_COMMIT_WAIT  = 3'd2;
    localparam logic [2:0] ST_MEMSET_ISSUE = 3'd3;
    localparam logic [2:0] ST_MEMSET_WAIT  = 3'd4;

endpackage

// File: rtl/lowest_set_index.sv
// Combinational priority encoder: index of the lowest set bit
// of a request vector plus a found flag.
module lowest_set_index #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_vec,
    output logic [IW-1:0] o_idx,
    output logic          o_found
);

    always_comb begin
        o_idx   = '0;
        o_found = 1'b0;
        // Scan downwards so the lowest set bit wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx   = IW'(i);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/framebuffer_cmd_scheduler.sv
// Sequences commit/memset commands onto framebuffer instances:
// commits one buffer at a time in index order, then parallel memsets.
module framebuffer_cmd_scheduler
    import framebuffer_sched_pkg::*;
#(
    parameter int NUM_BUFFERS    = FB_NUM_BUFFERS,
    parameter int PIXEL_WIDTH    = 16,
    parameter int TIMEOUT_CYCLES = 2 ** 20,
    parameter int IW = (NUM_BUFFERS > 1) ? $clog2(NUM_BUFFERS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               s_cmd_valid,
    output logic                               s_cmd_ready,
    input  logic [NUM_BUFFERS-1:0]             s_cmd_commit,
    input  logic [NUM_BUFFERS-1:0]             s_cmd_memset,
    input  logic [NUM_BUFFERS*PIXEL_WIDTH-1:0] s_cmd_clear,
    output logic [NUM_BUFFERS-1:0]             fb_apply,
    input  logic [NUM_BUFFERS-1:0]             fb_applied,
    output logic [NUM_BUFFERS-1:0]             fb_cmd_commit,
    output logic [NUM_BUFFERS-1:0]             fb_cmd_memset,
    output logic [NUM_BUFFERS*PIXEL_WIDTH-1:0] fb_clear_color,
    output logic [IW-1:0]                      stream_sel,
    output logic                               busy,
    output logic                               done,
    output logic                               timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [2:0]             r_state;
    logic [2:0]             w_state_n;
    logic [NUM_BUFFERS-1:0] r_c;
    logic [NUM_BUFFERS-1:0] r_m;
    logic [NUM_BUFFERS-1:0] w_c_n;
    logic [NUM_BUFFERS-1:0] w_m_n;
    logic [NUM_BUFFERS-1:0] r_wait;
    logic [NUM_BUFFERS-1:0] w_onehot;
    logic [NUM_BUFFERS-1:0] w_sel_onehot;
    logic [IW-1:0]          w_idx;
    logic [CW-1:0]          r_cnt;
    logic                   w_found;
    logic                   w_accept;
    logic                   w_in_wait;
    logic                   w_wait_ok;
    logic                   w_timeout;
    logic                   w_done_n;

    assign s_cmd_ready = (r_state == ST_IDLE) & (&fb_applied) & ~reset;
    assign w_accept    = s_cmd_valid & s_cmd_ready;

    assign w_in_wait = (r_state == ST_COMMIT_WAIT) |
                       (r_state == ST_MEMSET_WAIT);

    // r_wait holds the buffers pulsed by the last issue; the first
    // wait cycle is skipped because applied only drops a cycle later.
    assign w_wait_ok = w_in_wait & (r_cnt != '0) &
                       ((fb_applied & r_wait) == r_wait);
    assign w_timeout = w_in_wait & ~w_wait_ok & (r_cnt == CNT_LAST);

    assign w_sel_onehot = NUM_BUFFERS'(1) << stream_sel;
    assign w_onehot     = NUM_BUFFERS'(1) << w_idx;

    always_comb begin
        w_c_n = r_c;
        w_m_n = r_m;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_c_n = s_cmd_commit;
                    w_m_n = s_cmd_memset;
                end
            end
            ST_COMMIT_ISSUE: begin
                w_c_n = r_c & ~w_sel_onehot;
                w_m_n = r_m & ~w_sel_onehot;
            end
            ST_MEMSET_ISSUE: begin
                w_m_n = '0;
            end
            ST_COMMIT_WAIT, ST_MEMSET_WAIT: begin
                if (w_timeout) begin
                    w_c_n = '0;
                    w_m_n = '0;
                end
            end
            default: begin
                w_c_n = '0;
                w_m_n = '0;
            end
        endcase
    end

    lowest_set_index #(
        .N  (NUM_BUFFERS),
        .IW (IW)
    ) u_lsi (
        .i_vec   (w_c_n),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    always_comb begin
        w_state_n = r_state;
        w_done_n  = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_COMMIT_WAIT, ST_MEMSET_WAIT: begin
                if (w_accept | w_wait_ok) begin
                    if (w_found) begin
                        w_state_n = ST_COMMIT_ISSUE;
                    end else if (|w_m_n) begin
                        w_state_n = ST_MEMSET_ISSUE;
                    end else begin
                        w_state_n = ST_IDLE;
                        w_done_n  = 1'b1;
                    end
                end else if (w_timeout) begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_COMMIT_ISSUE: w_state_n = ST_COMMIT_WAIT;
            ST_MEMSET_ISSUE: w_state_n = ST_MEMSET_WAIT;
            default:         w_state_n = ST_IDLE;
        endcase
    end

    // Issue outputs are loaded on entry so they are visible
    // during the ISSUE cycle itself.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_c            <= '0;
            r_m            <= '0;
            r_wait         <= '0;
            r_cnt          <= '0;
            fb_apply       <= '0;
            fb_cmd_commit  <= '0;
            fb_cmd_memset  <= '0;
            fb_clear_color <= '0;
            stream_sel     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_c           <= w_c_n;
            r_m           <= w_m_n;
            fb_apply      <= '0;
            fb_cmd_commit <= '0;
            fb_cmd_memset <= '0;
            done          <= w_done_n;
            busy          <= (w_state_n != ST_IDLE) | w_done_n;
            r_cnt         <= w_in_wait ? r_cnt + 1'b1 : '0;
            if (w_accept) begin
                fb_clear_color <= s_cmd_clear;
            end
            if (w_timeout) begin
                timeout_err <= 1'b1;
            end
            if (w_state_n == ST_COMMIT_ISSUE) begin
                fb_apply      <= w_onehot;
                fb_cmd_commit <= w_onehot;
                fb_cmd_memset <= w_onehot & w_m_n;
                stream_sel    <= w_idx;
                r_wait        <= w_onehot;
            end
            if (w_state_n == ST_MEMSET_ISSUE) begin
                fb_apply      <= w_m_n;
                fb_cmd_memset <= w_m_n;
                r_wait        <= w_m_n;
            end
        end
    end

endmodule

// File: tb/tb_framebuffer_cmd_scheduler.sv
// Bench for framebuffer_cmd_scheduler with behavioural framebuffer
// models and an apply-sequence reference model.
module tb_framebuffer_cmd_scheduler;

    localparam int NB = 3;
    localparam int PW = 16;
    localparam int TO = 64;

    typedef struct packed {
        int          t;
        logic [NB-1:0] ap;
        logic [NB-1:0] cm;
        logic [NB-1:0] ms;
        logic [1:0]  sel;
    } ev_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_cmd_valid;
    logic              s_cmd_ready;
    logic [NB-1:0]     s_cmd_commit;
    logic [NB-1:0]     s_cmd_memset;
    logic [NB*PW-1:0]  s_cmd_clear;
    logic [NB-1:0]     fb_apply;
    logic [NB-1:0]     fb_applied;
    logic [NB-1:0]     fb_cmd_commit;
    logic [NB-1:0]     fb_cmd_memset;
    logic [NB*PW-1:0]  fb_clear_color;
    logic [1:0]        stream_sel;
    logic              busy;
    logic              done;
    logic              timeout_err;

    int            lat[NB];
    int            rem[NB];
    logic [NB-1:0] hold = '0;
    logic          kick = 1'b0;
    ev_t           ev_q[$];
    int            done_q[$];
    int            acc_q[$];
    int            cyc = 0;
    int            busy_cnt = 0;
    int            viol = 0;
    int            to_t = -1;
    int            nvec = 0;
    int            nerr = 0;
    logic [1:0]    exp_sel = 2'd0;
    logic          exp_to = 1'b0;

    always #5 clk = ~clk;

    framebuffer_cmd_scheduler #(
        .NUM_BUFFERS    (NB),
        .PIXEL_WIDTH    (PW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .s_cmd_valid    (s_cmd_valid),
        .s_cmd_ready    (s_cmd_ready),
        .s_cmd_commit   (s_cmd_commit),
        .s_cmd_memset   (s_cmd_memset),
        .s_cmd_clear    (s_cmd_clear),
        .fb_apply       (fb_apply),
        .fb_applied     (fb_applied),
        .fb_cmd_commit  (fb_cmd_commit),
        .fb_cmd_memset  (fb_cmd_memset),
        .fb_clear_color (fb_clear_color),
        .stream_sel     (stream_sel),
        .busy           (busy),
        .done           (done),
        .timeout_err    (timeout_err)
    );

    // Framebuffer model: applied drops after an apply and stays
    // low for lat cycles.
    always_comb begin
        fb_applied = '0;
        for (int i = 0; i < NB; i++)
            fb_applied[i] = (rem[i] == 0) && !hold[i];
    end

    always @(posedge clk) begin
        if (fb_apply != '0)
            ev_q.push_back(ev_t'({cyc, fb_apply, fb_cmd_commit,
                                  fb_cmd_memset, stream_sel}));
        if (done) done_q.push_back(cyc);
        if (s_cmd_valid && s_cmd_ready) acc_q.push_back(cyc);
        if (busy) busy_cnt <= busy_cnt + 1;
        if (timeout_err && to_t < 0) to_t <= cyc;
        if (((fb_apply & ~fb_applied) | (fb_cmd_commit & ~fb_apply) |
             (fb_cmd_memset & ~fb_apply)) != '0)
            viol <= viol + 1;
        for (int i = 0; i < NB; i++) begin
            if (reset || kick) rem[i] <= 0;
            else if (fb_apply[i]) rem[i] <= lat[i];
            else if (rem[i] > 0) rem[i] <= rem[i] - 1;
        end
        cyc <= cyc + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic run_cmd(input logic [NB-1:0] c, input logic [NB-1:0] m,
                           input logic [NB*PW-1:0] clr,
                           input int l0, input int l1, input int l2);
        int e0, d0, a0, b0, v0, ta, td, k, mx;
        logic [NB-1:0] rest;
        logic [1:0] sel;
        ev_t ev;
        ev_t exp_q[$];
        e0 = ev_q.size();
        d0 = done_q.size();
        a0 = acc_q.size();
        b0 = busy_cnt;
        v0 = viol;
        lat[0] = l0;
        lat[1] = l1;
        lat[2] = l2;
        s_cmd_commit = c;
        s_cmd_memset = m;
        s_cmd_clear  = clr;
        s_cmd_valid  = 1'b1;
        k = 0;
        while (acc_q.size() == a0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        s_cmd_valid = 1'b0;
        nvec++;
        if (acc_q.size() == a0) begin
            nerr++;
            $display("FAIL accept: got none, want accept within 50 cycles");
            return;
        end
        ta = acc_q[a0];
        // Reference: ascending commits, then leftover memsets in parallel.
        td = ta + 1;
        sel = exp_sel;
        for (int i = 0; i < NB; i++) begin
            if (c[i]) begin
                ev.t = td;
                ev.ap = NB'(1) << i;
                ev.cm = NB'(1) << i;
                ev.ms = m & (NB'(1) << i);
                ev.sel = 2'(i);
                exp_q.push_back(ev);
                sel = 2'(i);
                td += lat[i] + 2;
            end
        end
        rest = m & ~c;
        if (rest != '0) begin
            mx = 0;
            for (int i = 0; i < NB; i++)
                if (rest[i] && lat[i] > mx) mx = lat[i];
            ev.t = td;
            ev.ap = rest;
            ev.cm = '0;
            ev.ms = rest;
            ev.sel = sel;
            exp_q.push_back(ev);
            td += mx + 2;
        end
        exp_sel = sel;
        k = 0;
        while (done_q.size() == d0 && k < td - ta + 30) begin
            @(negedge clk);
            k++;
        end
        tick(4);
        nvec++;
        if (ev_q.size() - e0 != exp_q.size()) begin
            nerr++;
            $display("FAIL apply_count c=%b m=%b: got %0d, want %0d",
                     c, m, ev_q.size() - e0, exp_q.size());
        end
        for (int j = 0; j < exp_q.size(); j++) begin
            nvec++;
            if (e0 + j >= ev_q.size()) begin
                nerr++;
                $display("FAIL apply[%0d]: got none, want t=%0d",
                         j, exp_q[j].t);
            end else if (ev_q[e0+j] !== exp_q[j]) begin
                nerr++;
                $display("FAIL apply[%0d]: got t=%0d ap=%b cm=%b ms=%b sel=%0d, want t=%0d ap=%b cm=%b ms=%b sel=%0d",
                         j, ev_q[e0+j].t, ev_q[e0+j].ap, ev_q[e0+j].cm,
                         ev_q[e0+j].ms, ev_q[e0+j].sel, exp_q[j].t,
                         exp_q[j].ap, exp_q[j].cm, exp_q[j].ms, exp_q[j].sel);
            end
        end
        nvec++;
        if (done_q.size() - d0 != 1 || done_q[d0] != td) begin
            nerr++;
            $display("FAIL done: got %0d pulses first t=%0d, want 1 at t=%0d",
                     done_q.size() - d0,
                     (done_q.size() > d0) ? done_q[d0] : -1, td);
        end
        nvec++;
        if (busy_cnt - b0 != td - ta) begin
            nerr++;
            $display("FAIL busy_cycles: got %0d, want %0d",
                     busy_cnt - b0, td - ta);
        end
        nvec++;
        if (fb_clear_color !== clr) begin
            nerr++;
            $display("FAIL clear_color: got %h, want %h", fb_clear_color, clr);
        end
        nvec++;
        if (viol - v0 != 0 || timeout_err !== exp_to || s_cmd_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rules: got viol=%0d to=%b rdy=%b, want 0 %b 1",
                     viol - v0, timeout_err, exp_to, s_cmd_ready);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        s_cmd_valid = 1'b0;
        s_cmd_commit = '0;
        s_cmd_memset = '0;
        s_cmd_clear = '0;
        for (int i = 0; i < NB; i++) lat[i] = 1;
        tick(3);
        nvec++;
        if ({fb_apply, fb_cmd_commit, fb_cmd_memset, fb_clear_color,
             stream_sel, busy, done, timeout_err, s_cmd_ready} !== '0) begin
            nerr++;
            $display("FAIL reset_outs: got ap=%b cm=%b ms=%b clr=%h sel=%0d b=%b d=%b to=%b rdy=%b, want all 0",
                     fb_apply, fb_cmd_commit, fb_cmd_memset, fb_clear_color,
                     stream_sel, busy, done, timeout_err, s_cmd_ready);
        end
        reset = 1'b0;
        tick(1);
        nvec++;
        if (s_cmd_ready !== 1'b1) begin
            nerr++;
            $display("FAIL ready_after_reset: got %b, want 1", s_cmd_ready);
        end
    endtask

    task automatic test_commit_memset;
        run_cmd(3'b101, 3'b001, 48'h1111_2222_3333, 10, 10, 10);
    endtask

    task automatic test_memset_only;
        run_cmd(3'b000, 3'b110, 48'hAAAA_BBBB_CCCC, 1, 5, 40);
    endtask

    task automatic test_empty;
        run_cmd(3'b000, 3'b000, 48'h0123_4567_89AB, 3, 3, 3);
    endtask

    task automatic test_timeout;
        int e0, d0, a0, ta, k;
        e0 = ev_q.size();
        d0 = done_q.size();
        a0 = acc_q.size();
        lat[0] = 3;
        lat[1] = 1000;
        lat[2] = 3;
        s_cmd_commit = 3'b010;
        s_cmd_memset = 3'b000;
        s_cmd_valid = 1'b1;
        k = 0;
        while (acc_q.size() == a0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        s_cmd_valid = 1'b0;
        nvec++;
        if (acc_q.size() == a0) begin
            nerr++;
            $display("FAIL to_accept: got none, want accept");
            return;
        end
        ta = acc_q[a0];
        tick(100);
        nvec++;
        if (ev_q.size() - e0 != 1 || ev_q[e0].t != ta + 1) begin
            nerr++;
            $display("FAIL to_apply: got %0d applies, want 1 at t=%0d",
                     ev_q.size() - e0, ta + 1);
        end
        nvec++;
        if (done_q.size() != d0 || to_t != ta + 2 + TO) begin
            nerr++;
            $display("FAIL to_time: got done=%0d to_t=%0d, want 0 and %0d",
                     done_q.size() - d0, to_t, ta + 2 + TO);
        end
        nvec++;
        if ({timeout_err, busy, s_cmd_ready} !== 3'b100) begin
            nerr++;
            $display("FAIL to_state: got to,busy,rdy=%b, want 100",
                     {timeout_err, busy, s_cmd_ready});
        end
        kick = 1'b1;
        tick(1);
        kick = 1'b0;
        tick(1);
        exp_to = 1'b1;
        exp_sel = 2'd1;
        run_cmd(3'b011, 3'b100, 48'hDEAD_BEEF_0F0F, 2, 4, 6);
    endtask

    task automatic test_reset_mid;
        int e0, d0, a0, k;
        e0 = ev_q.size();
        d0 = done_q.size();
        a0 = acc_q.size();
        for (int i = 0; i < NB; i++) lat[i] = 10;
        s_cmd_commit = 3'b001;
        s_cmd_memset = 3'b001;
        s_cmd_clear = 48'h5555_6666_7777;
        s_cmd_valid = 1'b1;
        k = 0;
        while (acc_q.size() == a0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        s_cmd_valid = 1'b0;
        tick(2);
        reset = 1'b1;
        #1;
        nvec++;
        if (s_cmd_ready !== 1'b0) begin
            nerr++;
            $display("FAIL rst_mid_ready: got %b, want 0", s_cmd_ready);
        end
        tick(1);
        nvec++;
        if ({fb_apply, fb_cmd_commit, fb_cmd_memset, fb_clear_color,
             stream_sel, busy, done, timeout_err} !== '0) begin
            nerr++;
            $display("FAIL rst_mid_outs: got ap=%b clr=%h sel=%0d b=%b d=%b to=%b, want all 0",
                     fb_apply, fb_clear_color, stream_sel, busy, done,
                     timeout_err);
        end
        reset = 1'b0;
        tick(1);
        nvec++;
        if (s_cmd_ready !== 1'b1) begin
            nerr++;
            $display("FAIL rst_mid_ready_after: got %b, want 1", s_cmd_ready);
        end
        tick(20);
        nvec++;
        if (done_q.size() != d0 || ev_q.size() - e0 != 1) begin
            nerr++;
            $display("FAIL rst_mid_abort: got done=%0d applies=%0d, want 0 and 1",
                     done_q.size() - d0, ev_q.size() - e0);
        end
        exp_to = 1'b0;
        exp_sel = 2'd0;
    endtask

    task automatic test_ready_gate;
        int e0, d0, a0, r, k;
        e0 = ev_q.size();
        d0 = done_q.size();
        a0 = acc_q.size();
        hold = 3'b001;
        s_cmd_commit = '0;
        s_cmd_memset = '0;
        s_cmd_valid = 1'b1;
        tick(5);
        nvec++;
        if (acc_q.size() != a0 || s_cmd_ready !== 1'b0) begin
            nerr++;
            $display("FAIL gate_hold: got acc=%0d rdy=%b, want 0 and 0",
                     acc_q.size() - a0, s_cmd_ready);
        end
        r = cyc;
        hold = '0;
        k = 0;
        while (acc_q.size() == a0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        s_cmd_valid = 1'b0;
        tick(3);
        nvec++;
        if (acc_q.size() == a0 || acc_q[a0] != r) begin
            nerr++;
            $display("FAIL gate_accept: got t=%0d, want t=%0d",
                     (acc_q.size() > a0) ? acc_q[a0] : -1, r);
        end
        nvec++;
        if (done_q.size() - d0 != 1 || done_q[d0] != r + 1 ||
            ev_q.size() != e0) begin
            nerr++;
            $display("FAIL gate_done: got %0d dones, %0d applies, want 1 at t=%0d, 0",
                     done_q.size() - d0, ev_q.size() - e0, r + 1);
        end
    endtask

    task automatic test_random;
        logic [NB-1:0] c, m;
        logic [NB*PW-1:0] clr;
        for (int n = 0; n < 16; n++) begin
            c = NB'($urandom_range(0, 7));
            m = NB'($urandom_range(0, 7));
            clr = {16'($urandom), 16'($urandom), 16'($urandom)};
            run_cmd(c, m, clr, $urandom_range(1, 12),
                    $urandom_range(1, 12), $urandom_range(1, 12));
        end
    endtask

    initial begin
        test_reset();
        test_commit_memset();
        test_memset_only();
        test_empty();
        test_timeout();
        test_reset_mid();
        test_ready_gate();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/framebuffer_cmd_scheduler.md
# framebuffer_cmd_scheduler

Sequences apply/commit/memset commands onto up to NUM_BUFFERS framebuffer instances (color, depth, stencil) that share one AXIS output towards the display/memory path. Commits run strictly one buffer at a time, in ascending index order, and drive the stream-mux select. Memset-only requests are then applied to all remaining buffers in parallel. The block sits between the command parser and the framebuffer instances.

## Interface
- NUM_BUFFERS, 3: framebuffer instances controlled; index 0 is color.
- PIXEL_WIDTH, 16: clear-value width per buffer.
- TIMEOUT_CYCLES, 2^20: maximum wait for `applied` before abort.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- s_cmd_valid  in  1  command valid.
- s_cmd_ready  out  1  command accept.
- s_cmd_commit  in  NUM_BUFFERS  per-buffer commit request.
- s_cmd_memset  in  NUM_BUFFERS  per-buffer memset request.
- s_cmd_clear  in  NUM_BUFFERS*PIXEL_WIDTH  per-buffer clear value; slice i belongs to buffer i.
- fb_apply  out  NUM_BUFFERS  one-cycle apply pulse per buffer.
- fb_applied  in  NUM_BUFFERS  idle/finished flag from each buffer.
- fb_cmd_commit  out  NUM_BUFFERS  commit bit to each buffer.
- fb_cmd_memset  out  NUM_BUFFERS  memset bit to each buffer.
- fb_clear_color  out  NUM_BUFFERS*PIXEL_WIDTH  latched clear values.
- stream_sel  out  $clog2(NUM_BUFFERS)  AXIS mux select (the committing buffer).
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- timeout_err  out  1  sticky; set on timeout; cleared only by reset.

## Operation
- States: IDLE, COMMIT_ISSUE, COMMIT_WAIT, MEMSET_ISSUE, MEMSET_WAIT.

**IDLE**
- s_cmd_ready = (state==IDLE) & all fb_applied high & !reset.
- On valid&ready: latch commit mask C, memset mask M and clear values.
- Next state: COMMIT_ISSUE if C≠0, else MEMSET_ISSUE if M≠0.
- Empty command (C=0, M=0): done pulses on the next cycle, no apply is issued.

**COMMIT_ISSUE**
- idx = lowest set bit of C.
- Assert fb_apply[idx]=1, fb_cmd_commit[idx]=1, fb_cmd_memset[idx]=M[idx]; stream_sel=idx.
- Clear C[idx] and M[idx]; go to COMMIT_WAIT.
- The framebuffer itself performs commit followed by memset.

**COMMIT_WAIT**
- stream_sel holds idx.
- The first wait cycle ignores fb_applied (the buffer drops `applied` one cycle after apply).
- When fb_applied[idx]=1, go to COMMIT_ISSUE if C≠0, else MEMSET_ISSUE if M≠0, else IDLE with done.

**MEMSET_ISSUE**
- Assert fb_apply[i]=fb_cmd_memset[i]=M[i] for all i, fb_cmd_commit=0.
- Clear M; go to MEMSET_WAIT.

**MEMSET_WAIT**
- Same one-cycle ignore as COMMIT_WAIT.
- When every buffer issued in MEMSET_ISSUE shows fb_applied=1, go to IDLE with done.

**Timeout**
- A wait counter resets on entry to each WAIT state.
- Reaching TIMEOUT_CYCLES sets timeout_err, clears C/M and returns to IDLE without done.

**General rules**
- fb_apply is never asserted to a buffer whose fb_applied=0.
- fb_cmd_* are zero whenever the corresponding fb_apply is 0.
- A buffer with both C and M set receives a single apply carrying both bits. It is never memset a second time.

## Timing
- Reset values: fb_apply=0, fb_cmd_commit=0, fb_cmd_memset=0, fb_clear_color=0, stream_sel=0, busy=0, done=0, timeout_err=0, s_cmd_ready=0. State=IDLE.
- All outputs are registered except s_cmd_ready.
- Accept→first apply: 1 cycle.
- Applied-high→next apply: 1 cycle.
- Last applied-high→done: 1 cycle.
- busy is high from the cycle after accept through the done cycle.
- fb_clear_color is stable from accept until the next accept.
- stream_sel changes only in COMMIT_ISSUE.
- Reset mid-command: abort immediately, no apply issued in the reset cycle, outputs return to reset values.
- s_cmd_valid held while busy: ignored until IDLE; no input is sampled outside the accept cycle.

## Structure
- Package framebuffer_sched_pkg holds the state encoding, the default NUM_BUFFERS and the buffer index constants (COLOR=0, DEPTH=1, STENCIL=2).
- Sub-module lowest_set_index: combinational priority encoder, NUM_BUFFERS → index + found flag.
- The wait counter stays inline.

## Test plan
- C=3'b101, M=3'b001, behavioral FB models each taking 10 cycles → apply(0) with commit+memset, wait, apply(2) commit-only; stream_sel 0 then 2; done once; 2 applies total.
- C=0, M=3'b110 → a single cycle with fb_apply=3'b110, fb_cmd_commit=0; done after both applied rise, with skewed latencies of 5 and 40 cycles.
- C=0, M=0 → no fb_apply; done one cycle after accept; ready back next cycle.
- fb_applied[1] held low, TIMEOUT_CYCLES=64 → timeout_err=1 at wait cycle 64; IDLE; no done; next command accepted.
- Reset asserted during COMMIT_WAIT → all outputs at reset values the next cycle; s_cmd_ready low during reset, high after with all fb_applied high.
- fb_applied[0]=0 in IDLE → s_cmd_ready=0; valid pending; accept occurs the cycle fb_applied[0] rises.
